hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the in-order CPU core. It replaces single-operand load/store stall detection with four functions: multi-source operand checking, EX/MEM and MEM/WB forwarding selection, a counted load-use stall, and a scoreboard for the multi-cycle multiply/divide unit. It also flushes on taken branches. It sits beside the ID stage and drives the PC enable, the IF/ID buffer and the ID/EX buffer control-flush.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/hazard_scoreboard.sv | 51 +++++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_pkg : forwarding selects and hazard FSM states      rev 1.0
// ------------------------------------------------------------------
package cpu_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_LD_WAIT = 1'b1
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ------------------------------------------------------------------
// hazard_scoreboard : mul/div pending-result tracker       rev 1.0
// ------------------------------------------------------------------
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW     = 4,
  parameter int NSRC   = 2,
  parameter int MD_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC-1:0]    id_src_vld,
  input  logic               id_uses_md,
  input  logic [AW-1:0]      ex_dst,
  input  logic               ex_md_start,
  output logic               md_busy,
  output logic               md_hazard
);

  localparam int CW = $clog2(MD_LAT);

  logic [CW-1:0]   md_cnt;
  logic [AW-1:0]   md_dst_q;
  logic [NSRC-1:0] src_hit;

  assign md_busy = (md_cnt != '0);

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_hit[i] = id_src_vld[i] && (id_src[i*AW +: AW] == md_dst_q);
  end

  assign md_hazard = md_busy && (id_uses_md || (|src_hit));

  // A start while busy is illegal upstream; it is dropped rather than restarting the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt   <= '0;
      md_dst_q <= '0;
    end else if (ex_md_start && !md_busy) begin
      md_cnt   <= CW'(MD_LAT - 1);
      md_dst_q <= ex_dst;
    end else if (md_busy) begin
      md_cnt   <= md_cnt - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// hazard_ctrl : forwarding, load-use / mul-div stall, flush rev 1.0
// ------------------------------------------------------------------
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int AW         = 4,
  parameter int NSRC       = 2,
  parameter int LOAD_STALL = 1,
  parameter int MD_LAT     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC-1:0]    id_src_vld,
  input  logic               id_uses_md,
  input  logic [AW-1:0]      ex_dst,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic               ex_md_start,
  input  logic [AW-1:0]      mem_dst,
  input  logic               mem_regwrite,
  input  logic               branch_taken,
  output logic [NSRC*2-1:0]  fwd_sel,
  output logic               pc_pause,
  output logic               if_id_hold,
  output logic               if_id_flush,
  output logic               id_flush,
  output logic               md_busy
);

  localparam int LCW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

  hz_state_t       state;
  logic [LCW-1:0]  ld_cnt;
  logic [NSRC-1:0] ld_hit;
  logic            load_use;
  logic            md_hazard;
  logic            stall_req;

  hazard_scoreboard #(
    .AW     (AW),
    .NSRC   (NSRC),
    .MD_LAT (MD_LAT)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .id_src      (id_src),
    .id_src_vld  (id_src_vld),
    .id_uses_md  (id_uses_md),
    .ex_dst      (ex_dst),
    .ex_md_start (ex_md_start),
    .md_busy     (md_busy),
    .md_hazard   (md_hazard)
  );

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] src;
    logic          ex_match;
    logic          mem_match;
    assign src       = id_src[i*AW +: AW];
    assign ex_match  = id_src_vld[i] && ex_regwrite  && (src == ex_dst);
    assign mem_match = id_src_vld[i] && mem_regwrite && (src == mem_dst);
    assign ld_hit[i] = ex_match && ex_memread;
    // A load in EX has no result yet, so only MEM may still supply the operand.
    assign fwd_sel[i*2 +: 2] = (ex_match && !ex_memread) ? FWD_EX  :
                               mem_match                 ? FWD_MEM : FWD_RF;
  end

  assign load_use    = |ld_hit;
  assign stall_req   = load_use || md_hazard || (state == ST_LD_WAIT);
  assign pc_pause    = stall_req && !branch_taken;
  assign if_id_hold  = stall_req && !branch_taken;
  assign if_id_flush = branch_taken;
  assign id_flush    = stall_req || branch_taken;

  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      state  <= ST_RUN;
      ld_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (load_use && (LOAD_STALL > 1)) begin
            state  <= ST_LD_WAIT;
            ld_cnt <= LCW'(LOAD_STALL - 1);
          end
        end
        ST_LD_WAIT: begin
          if (ld_cnt <= LCW'(1)) begin
            state  <= ST_RUN;
            ld_cnt <= '0;
          end else begin
            ld_cnt <= ld_cnt - LCW'(1);
          end
        end
        default: begin
          state  <= ST_RUN;
          ld_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_hazard_ctrl : bench for hazard_ctrl (LOAD_STALL 1 and 3) rev 1.0
// ------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MDL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] id_src;
  logic [1:0] id_src_vld;
  logic       id_uses_md;
  logic [3:0] ex_dst;
  logic       ex_regwrite, ex_memread, ex_md_start;
  logic [3:0] mem_dst;
  logic       mem_regwrite, branch_taken;

  logic [3:0] fwd_a, fwd_b;
  logic       pp_a, ih_a, iff_a, idf_a, mb_a;
  logic       pp_b, ih_b, iff_b, idf_b, mb_b;
  logic [8:0] obs_a, obs_b;

  int n_tests = 0;
  int n_fail  = 0;

  // observed vector: {fwd_sel, pc_pause, if_id_hold, if_id_flush, id_flush, md_busy}
  assign obs_a = {fwd_a, pp_a, ih_a, iff_a, idf_a, mb_a};
  assign obs_b = {fwd_b, pp_b, ih_b, iff_b, idf_b, mb_b};

  localparam logic [8:0] STALL    = {4'b0000, 5'b11010};
  localparam logic [8:0] STALL_MB = {4'b0000, 5'b11011};
  localparam logic [8:0] BRFLUSH  = {4'b0000, 5'b00110};

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(4), .NSRC(2), .LOAD_STALL(1), .MD_LAT(MDL)) dut_a (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_vld(id_src_vld),
    .id_uses_md(id_uses_md), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_md_start(ex_md_start), .mem_dst(mem_dst),
    .mem_regwrite(mem_regwrite), .branch_taken(branch_taken),
    .fwd_sel(fwd_a), .pc_pause(pp_a), .if_id_hold(ih_a),
    .if_id_flush(iff_a), .id_flush(idf_a), .md_busy(mb_a)
  );

  hazard_ctrl #(.AW(4), .NSRC(2), .LOAD_STALL(3), .MD_LAT(MDL)) dut_b (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_vld(id_src_vld),
    .id_uses_md(id_uses_md), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_md_start(ex_md_start), .mem_dst(mem_dst),
    .mem_regwrite(mem_regwrite), .branch_taken(branch_taken),
    .fwd_sel(fwd_b), .pc_pause(pp_b), .if_id_hold(ih_b),
    .if_id_flush(iff_b), .id_flush(idf_b), .md_busy(mb_b)
  );

  // Reference model: remaining stall cycles and remaining busy cycles per instance.
  int         ld_rem [2];
  int         md_rem [2];
  logic [3:0] md_reg [2];

  function automatic logic model_lu();
    logic lu;
    lu = 1'b0;
    for (int i = 0; i < 2; i++)
      if (id_src_vld[i] && ex_regwrite && ex_memread && (id_src[i*4 +: 4] == ex_dst)) lu = 1'b1;
    return lu;
  endfunction

  function automatic logic [8:0] model_out(int k);
    logic [3:0] f;
    logic [3:0] s;
    logic       mdh, stall;
    f   = 4'b0000;
    mdh = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = id_src[i*4 +: 4];
      if (id_src_vld[i] && ex_regwrite && !ex_memread && s == ex_dst) f[i*2 +: 2] = 2'b01;
      else if (id_src_vld[i] && mem_regwrite && s == mem_dst)        f[i*2 +: 2] = 2'b10;
      if (md_rem[k] > 0 && id_src_vld[i] && s == md_reg[k]) mdh = 1'b1;
    end
    if (md_rem[k] > 0 && id_uses_md) mdh = 1'b1;
    stall = (model_lu() || mdh || ld_rem[k] > 0);
    return {f, stall && !branch_taken, stall && !branch_taken, branch_taken,
            stall || branch_taken, md_rem[k] > 0};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ld_rem[k] <= 0;
        md_rem[k] <= 0;
        md_reg[k] <= 4'd0;
      end else begin
        if (branch_taken)      ld_rem[k] <= 0;
        else if (ld_rem[k] > 0) ld_rem[k] <= ld_rem[k] - 1;
        else if (model_lu())   ld_rem[k] <= ((k == 1) ? 3 : 1) - 1;
        if (ex_md_start && md_rem[k] == 0) begin
          md_rem[k] <= MDL - 1;
          md_reg[k] <= ex_dst;
        end else if (md_rem[k] > 0) begin
          md_rem[k] <= md_rem[k] - 1;
        end
      end
    end
  end

  task automatic idle();
    id_src = 8'h00; id_src_vld = 2'b00; id_uses_md = 1'b0;
    ex_dst = 4'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_md_start = 1'b0;
    mem_dst = 4'd0; mem_regwrite = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    adv();
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_a !== 9'd0) begin n_fail++; $display("FAIL reset_a got %b want %b", obs_a, 9'd0); end
    n_tests++;
    if (obs_b !== 9'd0) begin n_fail++; $display("FAIL reset_b got %b want %b", obs_b, 9'd0); end
    adv();
  endtask

  task automatic test_forwarding();
    idle();
    ex_dst = 4'd3; ex_regwrite = 1'b1; mem_dst = 4'd3; mem_regwrite = 1'b1;
    id_src = 8'h03; id_src_vld = 2'b01;
    @(negedge clk);
    n_tests++;
    if (obs_a !== {4'b0001, 5'b0}) begin n_fail++; $display("FAIL fwd_ex got %b want %b", obs_a, {4'b0001, 5'b0}); end
    ex_regwrite = 1'b0;
    #1;
    n_tests++;
    if (obs_a !== {4'b0010, 5'b0}) begin n_fail++; $display("FAIL fwd_mem got %b want %b", obs_a, {4'b0010, 5'b0}); end
    ex_regwrite = 1'b1; id_src = 8'h33; id_src_vld = 2'b11;
    #1;
    n_tests++;
    if (obs_b !== {4'b0101, 5'b0}) begin n_fail++; $display("FAIL fwd_both_ex got %b want %b", obs_b, {4'b0101, 5'b0}); end
    ex_memread = 1'b1;
    #1;
    n_tests++;
    if (obs_a !== {4'b1010, 5'b11010}) begin n_fail++; $display("FAIL fwd_load_mem got %b want %b", obs_a, {4'b1010, 5'b11010}); end
    idle();
    adv();
  endtask

  task automatic test_load_use();
    logic [8:0] exp_b;
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 4'd5; id_src = 8'h50; id_src_vld = 2'b10;
    @(negedge clk);
    n_tests++;
    if (obs_a !== STALL) begin n_fail++; $display("FAIL lu_hit_a got %b want %b", obs_a, STALL); end
    n_tests++;
    if (obs_b !== STALL) begin n_fail++; $display("FAIL lu_hit_b got %b want %b", obs_b, STALL); end
    for (int c = 1; c <= 3; c++) begin
      adv();
      idle();
      exp_b = (c < 3) ? STALL : 9'd0;
      @(negedge clk);
      n_tests++;
      if (obs_a !== 9'd0) begin n_fail++; $display("FAIL lu_release_a c=%0d got %b want %b", c, obs_a, 9'd0); end
      n_tests++;
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL lu_count_b c=%0d got %b want %b", c, obs_b, exp_b); end
    end
    adv();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 4'd5; id_src = 8'h50; id_src_vld = 2'b01;
    @(negedge clk);
    n_tests++;
    if (obs_b !== 9'd0) begin n_fail++; $display("FAIL lu_invalid got %b want %b", obs_b, 9'd0); end
    idle();
    adv();
  endtask

  task automatic test_muldiv();
    logic [8:0] exp;
    idle();
    ex_md_start = 1'b1; ex_dst = 4'd7;
    @(negedge clk);
    n_tests++;
    if (obs_a !== 9'd0) begin n_fail++; $display("FAIL md_start got %b want %b", obs_a, 9'd0); end
    for (int c = 1; c <= 4; c++) begin
      adv();
      idle();
      id_src = 8'h07; id_src_vld = 2'b01;
      exp = (c < 4) ? STALL_MB : 9'd0;
      @(negedge clk);
      n_tests++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL md_stall_a c=%0d got %b want %b", c, obs_a, exp); end
      n_tests++;
      if (obs_b !== exp) begin n_fail++; $display("FAIL md_stall_b c=%0d got %b want %b", c, obs_b, exp); end
    end
    idle();
    adv();
  endtask

  task automatic test_branch();
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 4'd5; id_src = 8'h50; id_src_vld = 2'b10;
    adv();
    idle();
    branch_taken = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs_b !== BRFLUSH) begin n_fail++; $display("FAIL br_override_b got %b want %b", obs_b, BRFLUSH); end
    n_tests++;
    if (obs_a !== BRFLUSH) begin n_fail++; $display("FAIL br_flush_a got %b want %b", obs_a, BRFLUSH); end
    adv();
    idle();
    @(negedge clk);
    n_tests++;
    if (obs_b !== 9'd0) begin n_fail++; $display("FAIL br_run_b got %b want %b", obs_b, 9'd0); end
    adv();
  endtask

  task automatic test_reset_mid();
    idle();
    ex_md_start = 1'b1; ex_dst = 4'd9;
    adv();
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst = 4'd5; id_src = 8'h50; id_src_vld = 2'b10;
    adv();
    idle();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs_b !== STALL_MB) begin n_fail++; $display("FAIL rst_mid_pre got %b want %b", obs_b, STALL_MB); end
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs_b !== 9'd0) begin n_fail++; $display("FAIL rst_mid_b got %b want %b", obs_b, 9'd0); end
    n_tests++;
    if (obs_a !== 9'd0) begin n_fail++; $display("FAIL rst_mid_a got %b want %b", obs_a, 9'd0); end
    adv();
  endtask

  task automatic test_random();
    logic [8:0] exp_a, exp_b;
    for (int n = 0; n < 600; n++) begin
      id_src       = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
      id_src_vld   = 2'($urandom_range(0, 3));
      id_uses_md   = ($urandom_range(0, 7) == 0);
      ex_dst       = 4'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = ($urandom_range(0, 3) == 0);
      ex_md_start  = ($urandom_range(0, 9) == 0);
      mem_dst      = 4'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 11) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      exp_a = model_out(0);
      exp_b = model_out(1);
      n_tests++;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL rand_a n=%0d got %b want %b", n, obs_a, exp_a); end
      n_tests++;
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL rand_b n=%0d got %b want %b", n, obs_b, exp_b); end
      adv();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_muldiv();
    test_branch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
